// File: rtl/hfifo_pkt_reader.sv
// Drains length-prefixed packets from a handshake FIFO and re-emits the payload
// on a registered valid/ready stream with sop/eop. Optional counters: HFIFO_PKT_READER_STATS_EN.
module hfifo_pkt_reader #(
  parameter int DWIDTH = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_rdy,
  output logic              fifo_pop,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic              zero_len
`ifdef HFIFO_PKT_READER_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       zero_cnt
`endif
);

  localparam logic [0:0] S_HDR     = 1'b0;
  localparam logic [0:0] S_PAYLOAD = 1'b1;

  logic [0:0]       state;
  logic [LEN_W-1:0] rem;
  logic             first;
  logic             rdy_q;
  logic             avail;
  logic             slot_free;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_len   = fifo_dout[LEN_W-1:0];
  assign avail     = fifo_rdy & rdy_q;
  assign slot_free = ~out_valid | out_ready;
  // Headers also wait for a free slot so a stalled last beat is never overtaken.
  assign fifo_pop  = avail & slot_free;
  assign busy      = (state == S_PAYLOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HDR;
      rem       <= '0;
      first     <= 1'b0;
      rdy_q     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      zero_len  <= 1'b0;
    end else begin
      rdy_q    <= fifo_rdy & ~fifo_pop;
      zero_len <= 1'b0;
      if (slot_free) out_valid <= 1'b0;
      case (state)
        S_HDR: begin
          if (fifo_pop) begin
            if (hdr_len == '0) begin
              zero_len <= 1'b1;
            end else begin
              rem   <= hdr_len;
              first <= 1'b1;
              state <= S_PAYLOAD;
            end
          end
        end
        default: begin
          if (fifo_pop) begin
            out_data  <= fifo_dout;
            out_valid <= 1'b1;
            out_sop   <= first;
            first     <= 1'b0;
            out_eop   <= (rem == LEN_W'(1));
            rem       <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= S_HDR;
          end
        end
      endcase
    end
  end

`ifdef HFIFO_PKT_READER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt  <= '0;
      zero_cnt <= '0;
    end else begin
      if (out_valid && out_ready && out_eop) pkt_cnt <= pkt_cnt + 16'd1;
      if (zero_len) zero_cnt <= zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hfifo_pkt_reader.sv
// Self-checking bench for hfifo_pkt_reader: a queue-based FIFO model feeds packets,
// expected beats come from the packet list; protocol rules are checked every cycle.
module tb_hfifo_pkt_reader;
  localparam int DWIDTH = 8;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DWIDTH-1:0] fifo_dout = '0;
  logic              fifo_rdy = 1'b0;
  logic              fifo_pop;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_sop;
  logic              out_eop;
  logic              busy;
  logic              zero_len;
`ifdef HFIFO_PKT_READER_STATS_EN
  logic [15:0]       pkt_cnt;
  logic [15:0]       zero_cnt;
`endif

  always #5 clk = ~clk;

  hfifo_pkt_reader #(.DWIDTH(DWIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_rdy(fifo_rdy),
    .fifo_pop(fifo_pop), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .busy(busy), .zero_len(zero_len)
`ifdef HFIFO_PKT_READER_STATS_EN
    , .pkt_cnt(pkt_cnt), .zero_cnt(zero_cnt)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [DWIDTH-1:0] fifo_q[$];
  logic [DWIDTH-1:0] pend_q[$];
  logic [DWIDTH+1:0] obs_q[$];
  logic [DWIDTH+1:0] exp_q[$];
  int pops, bad_pop, bad_hold, bad_busy, zero_seen, exp_zero, exp_pops;
  int tot_pkts = 0, tot_zero = 0;
  int ready_mode = 1, feed_mode = 0;
  int mism_idx;
  logic rdyq_m = 1'b0, held = 1'b0, s_valid = 1'b0, s_busy = 1'b0;
  logic h_sop, h_eop;
  logic [DWIDTH-1:0] h_data;

  task automatic sync_fifo();
    fifo_rdy  = (fifo_q.size() != 0);
    fifo_dout = fifo_rdy ? fifo_q[0] : '0;
  endtask

  // One clock: sample at negedge, then advance the FIFO/ready model after posedge.
  task automatic tick();
    logic p, r;
    bit fresh;
    @(negedge clk);
    p = fifo_pop;
    r = fifo_rdy;
    if (p) begin
      pops++;
      if (!(r && rdyq_m) || (out_valid && !out_ready)) bad_pop++;
    end
    if (zero_len) zero_seen++;
    if (held && !(out_valid && out_data == h_data && out_sop == h_sop && out_eop == h_eop))
      bad_hold++;
    if (out_valid && !out_eop && !busy) bad_busy++;
    held = out_valid && !out_ready;
    h_data = out_data; h_sop = out_sop; h_eop = out_eop;
    s_valid = out_valid; s_busy = busy;
    if (out_valid && out_ready) obs_q.push_back({out_sop, out_eop, out_data});
    @(posedge clk); #1;
    rdyq_m = reset ? 1'b0 : (r && !p);
    if (p && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fresh = 1'b0;
    if (pend_q.size() != 0 && (feed_mode == 1 || (feed_mode == 2 && $urandom_range(1, 0) == 1))) begin
      fresh = (fifo_q.size() == 0);
      fifo_q.push_back(pend_q.pop_front());
    end
    if (ready_mode == 0) out_ready = 1'b0;
    else if (ready_mode == 1) out_ready = 1'b1;
    else out_ready = ($urandom_range(99, 0) < 65);
    sync_fifo();
    // A freshly non-empty FIFO may show a stale head for its first cycle.
    if (fresh) fifo_dout = DWIDTH'($urandom);
  endtask

  task automatic run_idle(input int max, output bit to);
    int quiet;
    quiet = 0;
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (fifo_q.size() == 0 && pend_q.size() == 0 && !s_valid && !s_busy) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin to = 1'b0; break; end
    end
  endtask

  task automatic start_test();
    obs_q.delete(); exp_q.delete();
    pops = 0; bad_pop = 0; bad_hold = 0; bad_busy = 0; zero_seen = 0;
    exp_zero = 0; exp_pops = 0;
  endtask

  task automatic put(input logic [DWIDTH-1:0] w, input bit preload);
    if (preload) fifo_q.push_back(w); else pend_q.push_back(w);
    exp_pops++;
    if (preload) sync_fifo();
  endtask

  task automatic add_pkt(input int len, input bit preload);
    logic [DWIDTH-1:0] w;
    put(DWIDTH'(len), preload);
    if (len == 0) exp_zero++;
    for (int i = 0; i < len; i++) begin
      w = DWIDTH'($urandom);
      put(w, preload);
      exp_q.push_back({(i == 0), (i == len - 1), w});
    end
  endtask

  function automatic int beat_mismatches();
    int n;
    n = 0; mism_idx = -1;
    if (obs_q.size() != exp_q.size()) return 1 + obs_q.size() + exp_q.size();
    foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
      n++;
      if (mism_idx < 0) mism_idx = i;
    end
    return n;
  endfunction

  function automatic void finish_model();
    foreach (exp_q[i]) if (exp_q[i][DWIDTH]) tot_pkts++;
    tot_zero += exp_zero;
  endfunction

  task automatic test_reset();
    tests_run++;
    if ({out_valid, out_sop, out_eop, busy, zero_len, fifo_pop} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got v/sop/eop/busy/zl/pop=%b expected 000000",
               {out_valid, out_sop, out_eop, busy, zero_len, fifo_pop});
    end
    tests_run++;
    if (out_data !== '0) begin
      tests_failed++; $display("FAIL reset_data: got %h expected 00", out_data);
    end
`ifdef HFIFO_PKT_READER_STATS_EN
    tests_run++;
    if ({pkt_cnt, zero_cnt} !== 32'd0) begin
      tests_failed++; $display("FAIL reset_stats: got pkt=%0d zero=%0d expected 0/0", pkt_cnt, zero_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    bit to;
    int n;
    start_test(); ready_mode = 1; feed_mode = 0;
    put(8'h03, 1); put(8'hA1, 1); put(8'hA2, 1); put(8'hA3, 1);
    exp_q.push_back({1'b1, 1'b0, 8'hA1});
    exp_q.push_back({1'b0, 1'b0, 8'hA2});
    exp_q.push_back({1'b0, 1'b1, 8'hA3});
    run_idle(200, to);
    n = beat_mismatches();
    tests_run++;
    if (to !== 1'b0 || n !== 0) begin
      tests_failed++;
      $display("FAIL basic_beats: got %0d beats timeout=%0d bad=%0d expected 3 A1,A2,A3", obs_q.size(), to, n);
    end
    tests_run++;
    if (pops !== 4) begin tests_failed++; $display("FAIL basic_pops: got %0d expected 4", pops); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    finish_model();
  endtask

  task automatic test_single();
    bit to;
    int n;
    start_test(); ready_mode = 1; feed_mode = 0;
    put(8'h01, 1); put(8'h5C, 1);
    exp_q.push_back({1'b1, 1'b1, 8'h5C});
    run_idle(200, to);
    n = beat_mismatches();
    tests_run++;
    if (to !== 1'b0 || n !== 0) begin
      tests_failed++;
      $display("FAIL single_beat: got %0d beats first=%h expected 1 beat sop+eop 5C",
               obs_q.size(), obs_q.size() ? obs_q[0] : 10'h0);
    end
    finish_model();
  endtask

  task automatic test_zero();
    bit to;
    int n;
    start_test(); ready_mode = 1; feed_mode = 0;
    put(8'h00, 1); exp_zero++;
    put(8'h02, 1); put(8'h11, 1); put(8'h22, 1);
    exp_q.push_back({1'b1, 1'b0, 8'h11});
    exp_q.push_back({1'b0, 1'b1, 8'h22});
    run_idle(200, to);
    n = beat_mismatches();
    tests_run++;
    if (to !== 1'b0 || n !== 0) begin
      tests_failed++; $display("FAIL zero_beats: got %0d beats bad=%0d expected 11,22", obs_q.size(), n);
    end
    tests_run++;
    if (zero_seen !== 1) begin tests_failed++; $display("FAIL zero_pulse: got %0d pulses expected 1", zero_seen); end
    finish_model();
`ifdef HFIFO_PKT_READER_STATS_EN
    tests_run++;
    if (zero_cnt !== 16'(tot_zero) || pkt_cnt !== 16'(tot_pkts)) begin
      tests_failed++;
      $display("FAIL zero_stats: got pkt=%0d zero=%0d expected %0d/%0d", pkt_cnt, zero_cnt, tot_pkts, tot_zero);
    end
`endif
  endtask

  task automatic test_stall();
    bit to;
    int n, p0, k;
    start_test(); ready_mode = 0; feed_mode = 0; out_ready = 1'b0;
    put(8'h03, 1); put(8'hB1, 1); put(8'hB2, 1); put(8'hB3, 1);
    exp_q.push_back({1'b1, 1'b0, 8'hB1});
    exp_q.push_back({1'b0, 1'b0, 8'hB2});
    exp_q.push_back({1'b0, 1'b1, 8'hB3});
    k = 0;
    while (!s_valid && k < 50) begin tick(); k++; end
    p0 = pops;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (pops !== p0) begin tests_failed++; $display("FAIL stall_pop: got %0d pops during stall expected 0", pops - p0); end
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'hB1 || out_sop !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_hold: got v=%b data=%h sop=%b expected 1 B1 1", out_valid, out_data, out_sop);
    end
    ready_mode = 1; out_ready = 1'b1;
    run_idle(200, to);
    n = beat_mismatches();
    tests_run++;
    if (to !== 1'b0 || n !== 0 || bad_hold !== 0) begin
      tests_failed++;
      $display("FAIL stall_beats: got %0d beats bad=%0d holdviol=%0d expected B1,B2,B3", obs_q.size(), n, bad_hold);
    end
    finish_model();
  endtask

  task automatic test_late_write();
    bit to;
    int n;
    start_test(); ready_mode = 1; feed_mode = 1;
    put(8'h02, 0); put(8'hC1, 0); put(8'hC2, 0);
    exp_q.push_back({1'b1, 1'b0, 8'hC1});
    exp_q.push_back({1'b0, 1'b1, 8'hC2});
    run_idle(200, to);
    n = beat_mismatches();
    tests_run++;
    if (bad_pop !== 0) begin tests_failed++; $display("FAIL late_pop_rule: got %0d illegal pops expected 0", bad_pop); end
    tests_run++;
    if (to !== 1'b0 || n !== 0) begin
      tests_failed++; $display("FAIL late_beats: got %0d beats bad=%0d expected C1,C2", obs_q.size(), n);
    end
    finish_model();
  endtask

  task automatic test_reset_mid();
    bit to;
    int n, k;
    start_test(); ready_mode = 1; feed_mode = 0;
    put(8'h03, 1); put(8'hB1, 1); put(8'hB2, 1); put(8'hB3, 1);
    exp_q.push_back({1'b1, 1'b0, 8'hB1});
    k = 0;
    while (obs_q.size() == 0 && k < 50) begin tick(); k++; end
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_out: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    fifo_q.delete(); pend_q.delete(); held = 1'b0; rdyq_m = 1'b0;
    tot_pkts = 0; tot_zero = 0;
    sync_fifo();
    tick(); tick();
    put(8'h01, 1); put(8'hD0, 1);
    exp_q.push_back({1'b1, 1'b1, 8'hD0});
    reset = 1'b0;
    run_idle(200, to);
    n = beat_mismatches();
    tests_run++;
    if (to !== 1'b0 || n !== 0) begin
      tests_failed++; $display("FAIL midreset_beats: got %0d beats bad=%0d expected B1 then D0", obs_q.size(), n);
    end
    finish_model();
  endtask

  task automatic test_random();
    bit to;
    int n, len;
    start_test(); ready_mode = 2; feed_mode = 2;
    for (int p = 0; p < 24; p++) begin
      len = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(6, 1);
      add_pkt(len, 0);
    end
    run_idle(4000, to);
    n = beat_mismatches();
    tests_run++;
    if (to !== 1'b0 || n !== 0) begin
      tests_failed++;
      $display("FAIL random_beats: got %0d beats expected %0d, bad=%0d first at %0d", obs_q.size(), exp_q.size(), n, mism_idx);
    end
    tests_run++;
    if (pops !== exp_pops || zero_seen !== exp_zero) begin
      tests_failed++;
      $display("FAIL random_counts: got pops=%0d zl=%0d expected %0d/%0d", pops, zero_seen, exp_pops, exp_zero);
    end
    tests_run++;
    if (bad_pop !== 0 || bad_hold !== 0 || bad_busy !== 0) begin
      tests_failed++;
      $display("FAIL random_protocol: got pop=%0d hold=%0d busy=%0d violations expected 0", bad_pop, bad_hold, bad_busy);
    end
    finish_model();
  endtask

  task automatic test_back_to_back();
    bit to;
    int n;
    start_test(); ready_mode = 1; feed_mode = 0;
    add_pkt(255, 1);
    add_pkt(1, 1);
    add_pkt(3, 1);
    run_idle(3000, to);
    n = beat_mismatches();
    tests_run++;
    if (to !== 1'b0 || n !== 0) begin
      tests_failed++;
      $display("FAIL b2b_beats: got %0d beats expected %0d, bad=%0d first at %0d", obs_q.size(), exp_q.size(), n, mism_idx);
    end
    tests_run++;
    if (pops !== 262) begin tests_failed++; $display("FAIL b2b_pops: got %0d expected 262", pops); end
    finish_model();
`ifdef HFIFO_PKT_READER_STATS_EN
    tests_run++;
    if (zero_cnt !== 16'(tot_zero) || pkt_cnt !== 16'(tot_pkts)) begin
      tests_failed++;
      $display("FAIL b2b_stats: got pkt=%0d zero=%0d expected %0d/%0d", pkt_cnt, zero_cnt, tot_pkts, tot_zero);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_basic();
    test_single();
    test_zero();
    test_stall();
    test_late_write();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
